l1_dcache: RTL and testbench
============================

# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache: the responder on the core's data-memory port. It answers `mem_read`/`mem_write` requests with a one-cycle `mem_resp` pulse and returns read data. It fills and evicts whole 256-bit lines through a line-granular physical-memory port. It sits between the core's data port (load/store buffer reads, ROB-committed stores) and the memory arbiter.

## Interface
Parameters:
- `S_INDEX`, 3: index bits; 2^S_INDEX sets.
- `S_OFFSET`, 5: byte-offset bits; fixed 32-byte line, only 5 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `mem_read` in 1: load request, held until `mem_resp`.
- `mem_write` in 1: store request, held until `mem_resp`.
- `mem_byte_enable` in 4: store byte mask; ignored for reads.
- `mem_address` in 32: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: store data.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: load word, valid while `mem_resp`=1.
- `pmem_read` out 1: line fill request, held until `pmem_resp`.
- `pmem_write` out 1: line writeback request, held until `pmem_resp`.
- `pmem_address` out 32: line address, low 5 bits zero.
- `pmem_wdata` out 256: evicted line.
- `pmem_rdata` in 256: fill line, valid with `pmem_resp`.
- `pmem_resp` in 1: physical-memory completion.
- `hit_count`, `miss_count`, `wb_count` out 32 each: present only under the configuration macro.

## Operation
- Address split: tag = [31:S_INDEX+5], index = [S_INDEX+4:5], word = [4:2].
- Per set: valid bit, dirty bit, tag, 256-bit data. Data is held in flops; no SRAM macro.
- States:
  - IDLE: lookup when `mem_read|mem_write`.
    - Hit → RESP.
    - Miss with victim valid and dirty → WRITEBACK.
    - Otherwise miss → ALLOCATE.
  - WRITEBACK: `pmem_write`=1, `pmem_address`={victim tag, index, 5'b0}, `pmem_wdata`=victim line. On `pmem_resp`: clear dirty, go to ALLOCATE.
  - ALLOCATE: `pmem_read`=1, `pmem_address`={req tag, index, 5'b0}. On `pmem_resp`: write line, set valid, clear dirty, write tag, return to IDLE. IDLE re-looks up and now hits.
  - RESP: `mem_resp`=1 for exactly one cycle, then unconditionally → IDLE. The held request is not resampled in this cycle.
- Read hit: `mem_rdata` = selected word, registered on the IDLE→RESP edge.
- Write hit: on the IDLE→RESP edge, merge `mem_wdata` bytes where `mem_byte_enable`=1 into the selected word and set dirty. `mem_rdata` is don't-care.
- Simultaneous `mem_read` and `mem_write`: the write is served first, because the core drives the store address in that case. The read is served afterwards if it is still held.
- `pmem_read` and `pmem_write` are never both 1.

## Timing
- Reset: every output is 0. Valid and dirty bits clear; data and tag arrays are not reset; state = IDLE. Counters reset to 0.
- Reset mid-miss: the pmem request drops in the cycle after the reset edge, and a late `pmem_resp` in IDLE is ignored.
- Hit latency: request visible in cycle N (IDLE) → `mem_resp` in cycle N+1.
- Clean miss: `pmem_read` rises in N+1. If `pmem_resp` arrives in cycle M, IDLE is at M+1 and `mem_resp` at M+2.
- Dirty miss adds the WRITEBACK phase before ALLOCATE; `pmem_read` rises the cycle after the writeback `pmem_resp`.
- `pmem_resp` asserted in IDLE or RESP is ignored.
- Back-to-back hits: at most one completion every 2 cycles.

## Configuration
- `DCACHE_PERF_COUNTERS_EN` defined: the `hit_count`, `miss_count` and `wb_count` ports exist.
  - `hit_count` increments on each RESP entry that did not follow an ALLOCATE for the same request.
  - `miss_count` increments on each IDLE→WRITEBACK or IDLE→ALLOCATE.
  - `wb_count` increments on each writeback `pmem_resp`.
  - All three saturate at 2^32−1.
- Undefined: the ports and counters are absent. Cache behaviour is identical.

## Structure
- Package `dcache_types`:
  - state enum {IDLE, RESP, WRITEBACK, ALLOCATE}
  - `dcache_line_t` (logic [255:0])
  - tag/index width constants derived from `S_INDEX`
- One sub-module, `dcache_array`: a parameterized width×2^S_INDEX flop array with synchronous write, per-byte write mask, async read and optional reset-to-zero. It is instantiated for data (256 wide, 32-bit byte mask), tag, valid and dirty.
- Control FSM and datapath merge live in `l1_dcache`.

## Test plan
- Cold read of 0x0000_0104: `pmem_read` with `pmem_address`=0x0000_0100. Return line word1=0xDEAD_BEEF; `mem_resp` 2 cycles after `pmem_resp`, `mem_rdata`=0xDEAD_BEEF. A repeat read gets `mem_resp` 1 cycle after request, with no pmem activity.
- Write hit to 0x104, be=4'b0011, wdata=0x1234_5678: a later read returns 0xDEAD_5678 and the line is dirty.
- Conflicting read of 0x0000_0204 (same index): `pmem_write` first with address 0x100 and wdata containing 0xDEAD_5678 at word1, then `pmem_read` 0x200, then `mem_resp`.
- `mem_read` and `mem_write` both held, with the store address on `mem_address`: the write completes first, and the read gets a separate `mem_resp` later.
- Assert `rst` during ALLOCATE: next cycle all outputs are 0. A subsequent `pmem_resp` is ignored, and a read of the same address misses again.
- With `DCACHE_PERF_COUNTERS_EN` defined, after the first three scenarios: `miss_count`=2, `wb_count`=1, `hit_count`=3.

Source files
------------

// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: controller states, line type and
// width helpers derived from the set-index width.
package dcache_types;

  localparam int OFFSET_W = 5;
  localparam int LINE_W   = 256;
  localparam int WORDS    = LINE_W / 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } dcache_state_e;

  typedef logic [LINE_W-1:0] dcache_line_t;

  function automatic int tag_w(input int s_index);
    return 32 - s_index - OFFSET_W;
  endfunction

  function automatic int num_sets(input int s_index);
    return 1 << s_index;
  endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Flop-based per-set storage: one synchronous byte-masked write port, one
// asynchronous read port, optional clear on reset.
module dcache_array #(
  parameter int WIDTH    = 256,
  parameter int S_INDEX  = 3,
  parameter bit RESET_EN = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [S_INDEX-1:0]       widx_i,
  input  logic [(WIDTH+7)/8-1:0]   wmask_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [S_INDEX-1:0]       ridx_i,
  output logic [WIDTH-1:0]         rdata_o
);

  localparam int SETS = 1 << S_INDEX;

  logic [SETS-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]           bmask;

  always_comb begin
    bmask = '0;
    for (int i = 0; i < WIDTH; i++) bmask[i] = wmask_i[i/8];
  end

  generate
    if (RESET_EN) begin : g_rst
      always_ff @(posedge clk_i) begin
        if (rst_i) mem_q <= '0;
        else if (we_i) mem_q[widx_i] <= (mem_q[widx_i] & ~bmask) | (wdata_i & bmask);
      end
    end else begin : g_norst
      logic unused_rst;
      assign unused_rst = rst_i;
      always_ff @(posedge clk_i) begin
        if (we_i) mem_q[widx_i] <= (mem_q[widx_i] & ~bmask) | (wdata_i & bmask);
      end
    end
  endgenerate

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Optional perf counters: define DCACHE_PERF_COUNTERS_EN.
module l1_dcache
  import dcache_types::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [31:0]  wb_count
`endif
);

  localparam int TAG_W = tag_w(S_INDEX);

  dcache_state_e state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] idx;
  logic [2:0]         word;
  logic               unused_ok;

  assign req_tag   = mem_address[31 -: TAG_W];
  assign idx       = mem_address[S_OFFSET +: S_INDEX];
  assign word      = mem_address[4:2];
  assign unused_ok = ^mem_address[1:0];

  dcache_line_t     data_rd, data_wdata;
  logic [31:0]      data_wmask;
  logic             data_we;
  logic [TAG_W-1:0] tag_rd;
  logic             tag_we;
  logic             valid_rd, valid_we, valid_wd;
  logic             dirty_rd, dirty_we, dirty_wd;
  logic             hit, req;
  logic [31:0]      store_mask;

  dcache_array #(.WIDTH(LINE_W), .S_INDEX(S_INDEX), .RESET_EN(1'b0)) u_data (
    .clk_i(clk), .rst_i(rst), .we_i(data_we), .widx_i(idx), .wmask_i(data_wmask),
    .wdata_i(data_wdata), .ridx_i(idx), .rdata_o(data_rd)
  );

  dcache_array #(.WIDTH(TAG_W), .S_INDEX(S_INDEX), .RESET_EN(1'b0)) u_tag (
    .clk_i(clk), .rst_i(rst), .we_i(tag_we), .widx_i(idx), .wmask_i('1),
    .wdata_i(req_tag), .ridx_i(idx), .rdata_o(tag_rd)
  );

  dcache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RESET_EN(1'b1)) u_valid (
    .clk_i(clk), .rst_i(rst), .we_i(valid_we), .widx_i(idx), .wmask_i(1'b1),
    .wdata_i(valid_wd), .ridx_i(idx), .rdata_o(valid_rd)
  );

  dcache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RESET_EN(1'b1)) u_dirty (
    .clk_i(clk), .rst_i(rst), .we_i(dirty_we), .widx_i(idx), .wmask_i(1'b1),
    .wdata_i(dirty_wd), .ridx_i(idx), .rdata_o(dirty_rd)
  );

  assign hit        = valid_rd && (tag_rd == req_tag);
  assign req        = mem_read | mem_write;
  assign store_mask = 32'(mem_byte_enable) << {word, 2'b00};

  // Writes take priority over reads: when both are held the address is the store's.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    data_we    = 1'b0;
    data_wmask = '0;
    data_wdata = '0;
    tag_we     = 1'b0;
    valid_we   = 1'b0;
    valid_wd   = 1'b0;
    dirty_we   = 1'b0;
    dirty_wd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_d = RESP;
            if (mem_write) begin
              data_we    = 1'b1;
              data_wmask = store_mask;
              data_wdata = {WORDS{mem_wdata}};
              dirty_we   = 1'b1;
              dirty_wd   = 1'b1;
            end else begin
              rdata_d = data_rd[{word, 5'd0} +: 32];
            end
          end else if (valid_rd && dirty_rd) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      RESP: state_d = IDLE;
      WRITEBACK: begin
        if (pmem_resp) begin
          dirty_we = 1'b1;
          dirty_wd = 1'b0;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (pmem_resp) begin
          data_we    = 1'b1;
          data_wmask = '1;
          data_wdata = pmem_rdata;
          tag_we     = 1'b1;
          valid_we   = 1'b1;
          valid_wd   = 1'b1;
          dirty_we   = 1'b1;
          dirty_wd   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_resp   = (state_q == RESP);
  assign mem_rdata  = rdata_q;
  assign pmem_read  = (state_q == ALLOCATE);
  assign pmem_write = (state_q == WRITEBACK);
  assign pmem_wdata = (state_q == WRITEBACK) ? data_rd : '0;

  always_comb begin
    pmem_address = '0;
    if (state_q == WRITEBACK)     pmem_address = {tag_rd, idx, {S_OFFSET{1'b0}}};
    else if (state_q == ALLOCATE) pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  logic        filled_q;
  logic [31:0] hit_q, miss_q, wb_q;
  logic        enter_resp, enter_miss, wb_done;

  assign enter_resp = (state_q == IDLE) && (state_d == RESP);
  assign enter_miss = (state_q == IDLE) && ((state_d == WRITEBACK) || (state_d == ALLOCATE));
  assign wb_done    = (state_q == WRITEBACK) && pmem_resp;

  // filled_q marks that the next RESP completes a request that just missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
    end else begin
      if ((state_q == ALLOCATE) && pmem_resp) filled_q <= 1'b1;
      else if (enter_resp)                    filled_q <= 1'b0;
      if (enter_resp && !filled_q && (hit_q != '1)) hit_q  <= hit_q + 32'd1;
      if (enter_miss && (miss_q != '1))             miss_q <= miss_q + 32'd1;
      if (wb_done && (wb_q != '1))                  wb_q   <= wb_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Randomized self-checking bench for l1_dcache against a set-level cache
// model with a sparse backing memory and a latency-randomizing pmem responder.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0]  hit_count, miss_count, wb_count;
`endif

  l1_dcache dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef DCACHE_PERF_COUNTERS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-set state plus sparse main memory keyed by line address.
  bit           m_v [8];
  bit           m_d [8];
  logic [23:0]  m_t [8];
  logic [255:0] m_l [8];
  logic [255:0] backing [logic [26:0]];
  int           e_hit = 0, e_miss = 0, e_wb = 0;

  logic [31:0]  last_rd;
  logic [31:0]  last_wb_addr, last_fill_addr;
  logic [255:0] last_wb_data;
  bit           last_fill;

  task automatic rand256(output logic [255:0] v);
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
  endtask

  task automatic fetch_line(input logic [26:0] la, output logic [255:0] v);
    if (!backing.exists(la)) begin
      rand256(v);
      backing[la] = v;
    end
    v = backing[la];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = 1'b0;
    end
    e_hit = 0; e_miss = 0; e_wb = 0;
  endtask

  // One request phase; base=1 when the request was already held through a RESP.
  task automatic run_phase(input bit is_wr, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int base);
    logic [2:0]   ix;
    logic [23:0]  tg;
    logic [2:0]   w;
    bit           hit, exp_wb, exp_fill;
    logic [31:0]  wb_addr, fill_addr, exp_rdata;
    logic [255:0] wb_data, fill_data, junk;
    int           n, resp_at, wb_n, dly;
    bit           wb_seen, fill_seen, wb_done, fill_done, done;

    ix = addr[7:5]; tg = addr[31:8]; w = addr[4:2];
    hit      = m_v[ix] && (m_t[ix] == tg);
    exp_wb   = !hit && m_v[ix] && m_d[ix];
    exp_fill = !hit;
    wb_addr  = {m_t[ix], ix, 5'b0};
    wb_data  = m_l[ix];
    fill_addr = {addr[31:5], 5'b0};
    fill_data = '0;
    if (exp_wb) backing[{m_t[ix], ix}] = m_l[ix];
    if (exp_fill) begin
      fetch_line(addr[31:5], fill_data);
      m_l[ix] = fill_data; m_t[ix] = tg; m_v[ix] = 1'b1; m_d[ix] = 1'b0;
    end
    exp_rdata = m_l[ix][w*32 +: 32];
    if (is_wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_l[ix][w*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_d[ix] = 1'b1;
    end
    e_hit  += hit ? 1 : 0;
    e_miss += exp_fill ? 1 : 0;
    e_wb   += exp_wb ? 1 : 0;

    n = 0; resp_at = exp_fill ? -1 : 1 + base; wb_n = -1; dly = 0;
    wb_seen = 0; fill_seen = 0; wb_done = 0; fill_done = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      pmem_resp = 1'b0;
      rand256(junk);
      pmem_rdata = junk;
      if (n > 200) begin
        chk("timeout", 1, 0);
        done = 1;
      end else begin
        if (pmem_read && pmem_write) chk("pmem_both", 1, 0);
        if (mem_resp) begin
          chk("resp_lat", n, resp_at);
          if (!is_wr) chk("rdata", mem_rdata, exp_rdata);
          chk("wb_seen", wb_seen, exp_wb);
          chk("fill_seen", fill_seen, exp_fill);
          last_rd = mem_rdata;
          last_fill = fill_seen;
          done = 1;
        end else begin
          if (pmem_write) begin
            if (!wb_seen) begin
              wb_seen = 1;
              chk("wb_exp", 1, exp_wb);
              chk("wb_n", n, 1 + base);
              chk("wb_addr", pmem_address, wb_addr);
              chk("wb_data", pmem_wdata, wb_data);
              last_wb_addr = pmem_address;
              last_wb_data = pmem_wdata;
              dly = $urandom_range(0, 3);
            end
            if (!wb_done) begin
              if (dly == 0) begin pmem_resp = 1'b1; wb_done = 1; wb_n = n; end
              else dly--;
            end
          end
          if (pmem_read) begin
            if (!fill_seen) begin
              fill_seen = 1;
              chk("fill_exp", 1, exp_fill);
              chk("fill_n", n, exp_wb ? wb_n + 1 : 1 + base);
              chk("fill_addr", pmem_address, fill_addr);
              last_fill_addr = pmem_address;
              dly = $urandom_range(0, 3);
            end
            if (!fill_done) begin
              if (dly == 0) begin
                pmem_resp = 1'b1; pmem_rdata = fill_data; fill_done = 1; resp_at = n + 2;
              end else dly--;
            end
          end
        end
      end
    end
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
    mem_read = rd; mem_write = wr;
    if (wr) begin
      run_phase(1'b1, addr, be, wd, 0);
      mem_write = 1'b0;
    end
    if (rd) begin
      run_phase(1'b0, addr, be, wd, wr ? 1 : 0);
      mem_read = 1'b0;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_resp"}, mem_resp, 0);
    chk({tag, "_rdata"}, mem_rdata, 0);
    chk({tag, "_pread"}, pmem_read, 0);
    chk({tag, "_pwrite"}, pmem_write, 0);
    chk({tag, "_paddr"}, pmem_address, 0);
    chk({tag, "_pwdata"}, pmem_wdata, 0);
  endtask

  initial begin
    logic [255:0] l0;
    logic [31:0]  wd, a;
    logic [23:0]  tg;
    logic [2:0]   ix, wi;
    int           k, op;

    rst = 1'b1; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
    mem_address = 0; mem_wdata = 0; pmem_rdata = '0; pmem_resp = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Cold read, repeat hit, write hit, dirty conflict.
    rand256(l0);
    l0[63:32] = 32'hDEAD_BEEF;
    backing[27'h8] = l0;
    do_op(1, 0, 32'h0000_0104, 4'h0, 32'h0);
    chk("cold_fill_addr", last_fill_addr, 32'h0000_0100);
    chk("cold_rdata", last_rd, 32'hDEAD_BEEF);
    do_op(1, 0, 32'h0000_0104, 4'hF, 32'h0);
    chk("rehit_nofill", last_fill, 0);
    chk("rehit_rdata", last_rd, 32'hDEAD_BEEF);
    do_op(0, 1, 32'h0000_0104, 4'b0011, 32'h1234_5678);
    do_op(1, 0, 32'h0000_0104, 4'h0, 32'h0);
    chk("merge_rdata", last_rd, 32'hDEAD_5678);
    do_op(1, 0, 32'h0000_0204, 4'h0, 32'h0);
    chk("evict_addr", last_wb_addr, 32'h0000_0100);
    chk("evict_word1", last_wb_data[63:32], 32'hDEAD_5678);
    chk("evict_fill_addr", last_fill_addr, 32'h0000_0200);
`ifdef DCACHE_PERF_COUNTERS_EN
    @(negedge clk);
    chk("perf_miss", miss_count, 2);
    chk("perf_wb", wb_count, 1);
    chk("perf_hit", hit_count, 3);
`endif

    // Read and write held together: store first, then the load sees it.
    wd = $urandom;
    do_op(1, 1, 32'h0000_0208, 4'hF, wd);
    chk("rdwr_rdata", last_rd, wd);

    // Reset while a fill is outstanding, then a late pmem_resp.
    @(negedge clk);
    mem_address = 32'h0000_1460; mem_read = 1'b1;
    k = 0;
    while (!pmem_read && k < 20) begin @(negedge clk); k++; end
    chk("rst_alloc_seen", pmem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    chk_outputs_zero("midrst");
    pmem_resp = 1'b1;
    rand256(l0);
    pmem_rdata = l0;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("late_resp_ignored", mem_resp, 0);
    chk("late_no_pread", pmem_read, 0);
    model_reset();
    do_op(1, 0, 32'h0000_1460, 4'h0, 32'h0);
    chk("rst_remiss", last_fill, 1);

    // Random traffic over a small tag pool so sets conflict and evict often.
    for (int i = 0; i < 250; i++) begin
      tg = 24'($urandom_range(0, 3));
      ix = 3'($urandom_range(0, 7));
      wi = 3'($urandom_range(0, 7));
      a  = {tg, ix, wi, 2'($urandom)};
      op = $urandom_range(0, 3);
      do_op(op != 2, op >= 2, a, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    @(negedge clk);
    chk("perf_hit_end", hit_count, e_hit);
    chk("perf_miss_end", miss_count, e_miss);
    chk("perf_wb_end", wb_count, e_wb);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
